counter_mm: RTL
===============

Name: counter_mm

Overview:
- Parametrised multi-mode counter. Successor to the team's basic enable-gated up-counter.
- Adds up/down direction, a programmable terminal limit, synchronous load and clear, and three counting modes: wrap, saturate and one-shot.
- Provides a terminal-count pulse, a sticky overflow flag and one-shot status.
- Used as a general timer/event-count primitive in datapath and control blocks.

Parameters:
- WIDTH, 8, counter and limit width in bits (WIDTH >= 2).
- RST_VAL, 0, value of cnt_o after reset; must be <= 2^WIDTH-1.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  count enable; one step per cycle while high.
- up_dn  input  1  1 = count up, 0 = count down.
- mode  input  2  00 = wrap, 01 = saturate, 10 = one-shot, 11 = reserved (behaves as wrap).
- limit  input  WIDTH  terminal value for counting up; reload value when wrapping down.
- clr  input  1  synchronous clear of count and overflow flag.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  value written on load.
- start  input  1  one-shot arm/restart.
- cnt_o  output  WIDTH  current count, registered.
- tc_o  output  1  terminal-count pulse, registered, one cycle.
- ovf_o  output  1  sticky overflow/underflow flag.
- busy_o  output  1  one-shot FSM in RUN.
- done_o  output  1  one-shot FSM in DONE.

Behaviour:
- Reset, asynchronous, while reset=1: cnt_o=RST_VAL, tc_o=0, ovf_o=0, FSM=IDLE, busy_o=0, done_o=0. Reset takes effect mid-operation with no completion.
- Per-edge priority: reset > clr > load > start > count step.
- clr: count=0, ovf_o=0, FSM=IDLE, tc_o=0.
- load: count=load_val. FSM state unchanged. No tc_o, no ovf_o change.
- Step happens only when en=1 and the counter is allowed to count: mode!=10, or mode=10 with FSM=RUN.
- Up terminal: count >= limit. Covers limit lowered below the current count.
- Down terminal: count == 0.
- Wrap mode:
  - Up at terminal -> 0.
  - Down at terminal -> limit.
  - Either: tc_o=1 next cycle, ovf_o set.
- Saturate mode:
  - At terminal, count holds.
  - tc_o pulses only on the step that reaches the terminal, i.e. the non-terminal -> terminal transition.
  - A further en at terminal sets ovf_o. No tc_o.
- tc_o is a registered pulse, high for exactly one cycle after the edge where its condition was met. Consecutive wraps (limit=0, up) give tc_o high every enabled cycle.
- One-shot FSM (mode=10):
  - IDLE: count holds. start -> count = 0 if up_dn=1, else limit; go to RUN.
  - RUN: steps on en. A step reaching the terminal (up: count+1 == limit, or count >= limit; down: count == 1, or already 0) writes the terminal value. tc_o pulses next cycle; go to DONE.
  - DONE: count holds. start re-arms as from IDLE. en is ignored.
  - start in RUN restarts the count; no tc_o.
  - busy_o = (state==RUN). done_o = (state==DONE). Both are registered state decodes.
- When mode != 10, the FSM is forced to IDLE on the next edge. Switching into mode 10 requires start.
- Arithmetic is WIDTH bits unsigned. No intermediate result wider than WIDTH reaches cnt_o.
- en=0 holds all state. tc_o returns to 0.
- up_dn, mode and limit may change on any cycle. They take effect at the next edge.

Test Plan:
- WIDTH=4, reset -> cnt_o=0, tc_o=0, ovf_o=0, busy_o=0. Assert reset mid-count at 7 -> cnt_o=0 immediately, without waiting for a clock edge.
- Wrap up, limit=5, en=1, 8 cycles -> cnt_o 1,2,3,4,5,0,1,2. tc_o high only the cycle after the 5->0 edge. ovf_o set there.
- Wrap down, limit=9, load 1 -> cnt_o 0,9,8. Single tc_o pulse. ovf_o=1. Then clr -> cnt_o=0, ovf_o=0.
- Saturate up, limit=15, load 13, en for 5 cycles -> 14,15,15,15,15. One tc_o pulse on reaching 15. ovf_o set on the first held step.
- One-shot down, limit=3, start then en -> busy_o=1, cnt_o 3,2,1,0. tc_o once. done_o=1, busy_o=0. Further en leaves cnt_o at 0. start again -> cnt_o=3, busy_o=1.
- Simultaneous clr+load+en at count 6 -> cnt_o=0. load+en with load_val=10 -> cnt_o=10, no step. Lower limit to 4 while count=10 in wrap-up -> next step gives cnt_o=0 and tc_o.

Source files
------------

// File: rtl/counter_mm.sv
// Multi-mode up/down counter (wrap, saturate, one-shot); outputs registered, one cycle from inputs to cnt_o/tc_o.
// No backpressure: one step per enabled cycle, priority clr > load > start > step.
module counter_mm #(
    parameter int WIDTH   = 8,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] limit,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    output logic [WIDTH-1:0] cnt_o,
    output logic             tc_o,
    output logic             ovf_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] RSTV = WIDTH'(RST_VAL);
    localparam logic [1:0]       M_SAT = 2'b01;
    localparam logic [1:0]       M_ONE = 2'b10;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;

    logic             oneshot;
    logic             step;
    logic             up_term;
    logic             dn_term;
    logic             os_term;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] cnt_dec;

    assign oneshot = (mode == M_ONE);
    assign step    = en && (!oneshot || state_q == RUN);
    assign cnt_inc = cnt_q + ONE;
    assign cnt_dec = cnt_q - ONE;
    // ">=" so that lowering limit below the current count still terminates
    assign up_term = (cnt_q >= limit);
    assign dn_term = (cnt_q == ZERO);
    assign os_term = up_dn ? (up_term || cnt_inc == limit) : (cnt_q <= ONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= RSTV;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr || !oneshot)
            state_d = IDLE;
        else if (load)
            state_d = state_q;
        else if (start)
            state_d = RUN;
        else if (step && os_term)
            state_d = DONE;
    end

    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        ovf_d = ovf_q;
        if (clr) begin
            cnt_d = ZERO;
            ovf_d = 1'b0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (oneshot && start) begin
            cnt_d = up_dn ? ZERO : limit;
        end else if (step) begin
            if (oneshot) begin
                if (os_term) begin
                    cnt_d = up_dn ? limit : ZERO;
                    tc_d  = 1'b1;
                end else begin
                    cnt_d = up_dn ? cnt_inc : cnt_dec;
                end
            end else if (mode == M_SAT) begin
                // tc only on the transition into the terminal; stepping at it flags overflow
                if (up_dn) begin
                    if (up_term) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                        tc_d  = (cnt_inc >= limit);
                    end
                end else begin
                    if (dn_term) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_dec;
                        tc_d  = (cnt_q == ONE);
                    end
                end
            end else begin
                if (up_dn ? up_term : dn_term) begin
                    cnt_d = up_dn ? ZERO : limit;
                    tc_d  = 1'b1;
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = up_dn ? cnt_inc : cnt_dec;
                end
            end
        end
    end

    always_comb begin
        busy_o = (state_q == RUN);
        done_o = (state_q == DONE);
    end

    assign cnt_o = cnt_q;
    assign tc_o  = tc_q;
    assign ovf_o = ovf_q;

endmodule
